// File: rtl/v_dresizer_seq.sv
// Sequencer for the 8-pixel-per-clock downsizer: tracks beat/line position on the
// monitored stream, issues capture/pair/drop decisions and reports geometry errors.
module v_dresizer_seq #(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             cfg_col_down,
  input  logic             cfg_line_down,
  input  logic [CNT_W-1:0] cfg_hsize,
  input  logic [CNT_W-1:0] cfg_vsize,
  input  logic             cfg_update,
  output logic             cfg_pending,
  output logic             act_col_down,
  output logic             act_line_down,
  output logic             beat_phase,
  output logic             line_drop,
  output logic             beat_emit,
  output logic             frame_active,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             err_early_eol,
  output logic             err_late_eol,
  output logic             err_sof_mid,
  output logic             err_odd_line
);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t state;

  // Shadowed configuration, promoted to the active set on the next SOF beat.
  logic             sh_col_down;
  logic             sh_line_down;
  logic [CNT_W-1:0] sh_hsize;
  logic [CNT_W-1:0] sh_vsize;
  logic [CNT_W-1:0] act_hsize;
  logic [CNT_W-1:0] act_vsize;

  logic             acc;
  logic             sof;
  logic             take_cfg;
  logic             frame_ok;
  logic             eff_col_down;
  logic             eff_line_down;
  logic [CNT_W-1:0] eff_hsize;
  logic [CNT_W-1:0] eff_vsize;
  logic [CNT_W-1:0] pos_beat;
  logic [CNT_W-1:0] pos_line;
  logic [CNT_W:0]   beat_next;
  logic [CNT_W:0]   line_next;
  logic [CNT_W-1:0] beat_inc_sat;

  // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
  always_comb begin
    acc      = s_axis_tvalid & s_axis_tready;
    sof      = acc & s_axis_tuser;
    take_cfg = sof & cfg_pending;

    // The SOF beat that promotes a pending config is already governed by it.
    eff_col_down  = take_cfg ? sh_col_down  : act_col_down;
    eff_line_down = take_cfg ? sh_line_down : act_line_down;
    eff_hsize     = take_cfg ? sh_hsize     : act_hsize;
    eff_vsize     = take_cfg ? sh_vsize     : act_vsize;

    pos_beat = s_axis_tuser ? '0 : beat_cnt;
    pos_line = s_axis_tuser ? '0 : line_cnt;

    // One extra bit keeps the +1 from wrapping inside the size compares.
    beat_next    = {1'b0, pos_beat} + 1'b1;
    line_next    = {1'b0, pos_line} + 1'b1;
    beat_inc_sat = beat_next[CNT_W] ? '1 : beat_next[CNT_W-1:0];

    frame_ok   = (state == ACTIVE) | s_axis_tuser;
    beat_phase = pos_beat[0];
    line_drop  = eff_line_down & pos_line[0];
    beat_emit  = acc & frame_ok & ~line_drop & (~eff_col_down | beat_phase);
  end

  assign frame_active = (state == ACTIVE);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sh_col_down   <= 1'b0;
      sh_line_down  <= 1'b0;
      sh_hsize      <= CNT_W'(1);
      sh_vsize      <= CNT_W'(1);
      act_col_down  <= 1'b0;
      act_line_down <= 1'b0;
      act_hsize     <= CNT_W'(1);
      act_vsize     <= CNT_W'(1);
      cfg_pending   <= 1'b0;
    end else begin
      if (take_cfg) begin
        act_col_down  <= sh_col_down;
        act_line_down <= sh_line_down;
        act_hsize     <= sh_hsize;
        act_vsize     <= sh_vsize;
        cfg_pending   <= 1'b0;
      end
      // NOTE: non-blocking semantics make this later assignment win, so an update
      // coinciding with the promoting SOF keeps cfg_pending set for the new shadow.
      if (cfg_update) begin
        sh_col_down  <= cfg_col_down;
        sh_line_down <= cfg_line_down;
        sh_hsize     <= cfg_hsize;
        sh_vsize     <= cfg_vsize;
        cfg_pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= WAIT_SOF;
      beat_cnt      <= '0;
      line_cnt      <= '0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_sof_mid   <= 1'b0;
      err_odd_line  <= 1'b0;
    end else begin
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_sof_mid   <= 1'b0;
      err_odd_line  <= 1'b0;

      // SOF restarts position via pos_*, then the EOL / mid-line rules apply.
      if (acc && frame_ok) begin
        err_sof_mid <= s_axis_tuser & (state == ACTIVE);
        if (s_axis_tlast) begin
          err_early_eol <= (beat_next < {1'b0, eff_hsize});
          err_odd_line  <= eff_col_down & ~pos_beat[0];
          beat_cnt      <= '0;
          if (line_next == {1'b0, eff_vsize}) begin
            line_cnt <= '0;
            state    <= WAIT_SOF;
          end else begin
            line_cnt <= line_next[CNT_W-1:0];
            state    <= ACTIVE;
          end
        end else begin
          // Fires only on the beat that reaches hsize; the counter moves past it.
          err_late_eol <= (beat_next == {1'b0, eff_hsize});
          beat_cnt     <= beat_inc_sat;
          line_cnt     <= pos_line;
          state        <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_v_dresizer_seq.sv
// Directed bench for v_dresizer_seq: hand-computed expectations checked with
// immediate assertions, inputs driven 1 ns after the rising edge.
module tb_v_dresizer_seq;

  localparam int CNT_W = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tuser;
  logic             s_axis_tlast;
  logic             cfg_col_down;
  logic             cfg_line_down;
  logic [CNT_W-1:0] cfg_hsize;
  logic [CNT_W-1:0] cfg_vsize;
  logic             cfg_update;
  logic             cfg_pending;
  logic             act_col_down;
  logic             act_line_down;
  logic             beat_phase;
  logic             line_drop;
  logic             beat_emit;
  logic             frame_active;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             err_early_eol;
  logic             err_late_eol;
  logic             err_sof_mid;
  logic             err_odd_line;

  int n_pass  = 0;
  int n_total = 0;
  int emits   = 0;
  logic err_seen;

  always #5 aclk = ~aclk;

  v_dresizer_seq #(.CNT_W(CNT_W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .cfg_col_down  (cfg_col_down),
    .cfg_line_down (cfg_line_down),
    .cfg_hsize     (cfg_hsize),
    .cfg_vsize     (cfg_vsize),
    .cfg_update    (cfg_update),
    .cfg_pending   (cfg_pending),
    .act_col_down  (act_col_down),
    .act_line_down (act_line_down),
    .beat_phase    (beat_phase),
    .line_drop     (line_drop),
    .beat_emit     (beat_emit),
    .frame_active  (frame_active),
    .beat_cnt      (beat_cnt),
    .line_cnt      (line_cnt),
    .err_early_eol (err_early_eol),
    .err_late_eol  (err_late_eol),
    .err_sof_mid   (err_sof_mid),
    .err_odd_line  (err_odd_line)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one accepted beat; combinational outputs are settled on return.
  task automatic beat(input logic u, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    #4;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_update    = 1'b0;
    err_seen      = err_seen | err_early_eol | err_late_eol | err_sof_mid | err_odd_line;
  endtask

  task automatic load_cfg(input logic cd, input logic ld, input int hs, input int vs);
    cfg_col_down  = cd;
    cfg_line_down = ld;
    cfg_hsize     = CNT_W'(hs);
    cfg_vsize     = CNT_W'(vs);
    cfg_update    = 1'b1;
    tick();
  endtask

  function automatic logic [3:0] errs();
    return {err_early_eol, err_late_eol, err_sof_mid, err_odd_line};
  endfunction

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tready = 1'b1;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_col_down  = 1'b0;
    cfg_line_down = 1'b0;
    cfg_hsize     = '0;
    cfg_vsize     = '0;
    cfg_update    = 1'b0;
    err_seen      = 1'b0;
    tick();
    tick();

    check("rst_pending", cfg_pending, 0);
    check("rst_act", {act_col_down, act_line_down}, 0);
    check("rst_active", frame_active, 0);
    check("rst_cnt", {beat_cnt, line_cnt}, 0);
    check("rst_err", errs(), 0);
    aresetn = 1'b1;

    // Beats before any SOF are ignored
    beat(1'b0, 1'b0);
    check("pre_sof_emit", beat_emit, 0);
    tick();
    check("pre_sof_cnt", beat_cnt, 0);
    check("pre_sof_active", frame_active, 0);

    // 4x4 frame, both decimations
    load_cfg(1'b1, 1'b1, 4, 4);
    check("cfg_pend_set", cfg_pending, 1);
    check("cfg_act_hold", act_col_down, 0);
    err_seen = 1'b0;
    for (int ln = 0; ln < 4; ln++) begin
      for (int b = 0; b < 4; b++) begin
        beat(ln == 0 && b == 0, b == 3);
        check($sformatf("f1_emit_l%0d_b%0d", ln, b), beat_emit, ((ln % 2) == 0) && ((b % 2) == 1));
        if (beat_emit) emits++;
        tick();
      end
    end
    check("f1_emit_total", emits, 4);
    check("f1_no_err", err_seen, 0);
    check("f1_act", {act_col_down, act_line_down, cfg_pending}, 3'b110);
    check("f1_done", {frame_active, line_cnt}, 0);

    // Frame 2: config change while active, then SOF in line 1 beat 2
    beat(1'b1, 1'b0);
    check("f2_sof_emit", beat_emit, 0);
    tick();
    beat(1'b0, 1'b0);
    check("f2_b1_emit", beat_emit, 1);
    tick();
    load_cfg(1'b0, 1'b1, 4, 4);
    check("mid_pend", {cfg_pending, act_col_down}, 2'b11);
    beat(1'b0, 1'b0);
    tick();
    beat(1'b0, 1'b1);
    tick();
    check("f2_eol_cnt", {beat_cnt, line_cnt}, {16'd0, 16'd1});
    check("mid_pend_hold", {cfg_pending, act_col_down}, 2'b11);
    beat(1'b0, 1'b0);
    check("f2_l1_drop", {line_drop, beat_emit}, 2'b10);
    tick();
    beat(1'b0, 1'b0);
    tick();
    beat(1'b1, 1'b0);
    check("sof_mid_comb", {beat_phase, line_drop, beat_emit}, 3'b001);
    tick();
    check("sof_mid_err", err_sof_mid, 1);
    check("sof_mid_cnt", {beat_cnt, line_cnt}, {16'd1, 16'd0});
    check("sof_cfg_apply", {cfg_pending, act_col_down, act_line_down}, 3'b001);

    // Short line: tlast on beat 2 with hsize 4
    beat(1'b0, 1'b0);
    check("nodec_emit", beat_emit, 1);
    tick();
    check("sof_mid_pulse", err_sof_mid, 0);
    beat(1'b0, 1'b1);
    tick();
    check("early_err", errs(), 4'b1000);
    check("early_cnt", {beat_cnt, line_cnt}, {16'd0, 16'd1});

    // Long line: no tlast at beat 3, tlast on beat 5
    beat(1'b0, 1'b0);
    check("long_drop", {line_drop, beat_emit}, 2'b10);
    tick();
    check("early_pulse", err_early_eol, 0);
    beat(1'b0, 1'b0);
    tick();
    beat(1'b0, 1'b0);
    tick();
    beat(1'b0, 1'b0);
    tick();
    check("late_err", errs(), 4'b0100);
    check("late_cnt", beat_cnt, 4);
    beat(1'b0, 1'b0);
    tick();
    check("late_once", {err_late_eol, beat_cnt}, {1'b0, 16'd5});
    beat(1'b0, 1'b1);
    tick();
    check("long_eol", {errs(), beat_cnt, line_cnt}, {4'b0000, 16'd0, 16'd2});

    // Reset mid-frame
    check("pre_rst_active", frame_active, 1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("mid_rst_state", {frame_active, cfg_pending, act_col_down, act_line_down}, 0);
    check("mid_rst_cnt", {beat_cnt, line_cnt}, 0);
    beat(1'b0, 1'b0);
    check("post_rst_emit", beat_emit, 0);
    tick();
    check("post_rst_cnt", {frame_active, beat_cnt}, 0);

    // One-beat frame with reset sizes (1x1)
    beat(1'b1, 1'b1);
    check("one_beat_emit", beat_emit, 1);
    tick();
    check("one_beat_done", {frame_active, beat_cnt, line_cnt}, 0);
    check("one_beat_err", errs(), 0);

    // Odd beat count with column decimation: 3-beat single-line frame
    load_cfg(1'b1, 1'b0, 3, 1);
    beat(1'b1, 1'b0);
    check("odd_b0_emit", beat_emit, 0);
    tick();
    beat(1'b0, 1'b0);
    check("odd_b1_emit", beat_emit, 1);
    tick();
    beat(1'b0, 1'b1);
    check("odd_b2_comb", {beat_phase, beat_emit}, 2'b00);
    tick();
    check("odd_err", errs(), 4'b0001);
    check("odd_done", frame_active, 0);
    tick();
    check("odd_pulse", err_odd_line, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
